div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be as follows, in this order:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- valid  in  1  divide request from decode/execute.
- op  in  2  operation select: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- word  in  1  1 = W variant (32-bit operation).
- a  in  64  dividend (word_t).
- b  in  64  divisor (word_t).
- flush  in  1  kill any in-flight operation.
- ready  out  1  idle and able to accept a request.
- stall  out  1  hold the upstream pipeline.
- done  out  1  result valid; one-cycle pulse.
- result  out  64  quotient or remainder (word_t).

Function
REQ-003 The FSM SHALL have three states, IDLE, BUSY and DONE; ready SHALL equal (state==IDLE).
REQ-004 A request SHALL be accepted on a cycle with valid=1, ready=1 and flush=0; op, word, a and b SHALL be latched on that edge.
REQ-005 Operand conditioning at accept SHALL be:
- word=1, signed op (DIV/REM): sign-extend a[31:0] and b[31:0].
- word=1, unsigned op (DIVU/REMU): zero-extend a[31:0] and b[31:0].
- word=0: use a and b unchanged.
REQ-006 For signed ops, the datapath SHALL divide absolute values (unsigned 64-bit magnitudes, so |-2^63| = 2^63) and apply sign fix-up at completion.
REQ-007 With a latched b that is nonzero, accept SHALL go to BUSY with the iteration counter set to 64.
REQ-008 Each BUSY cycle SHALL perform one restoring step and decrement the counter:
- shift {rem, quo} left by 1;
- if rem >= divisor: subtract, and set quo LSB to 1.
REQ-009 When the counter reaches 0, the FSM SHALL go to DONE on the next edge.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-011 Latency for b!=0 SHALL be fixed: accept edge at cycle T, done=1 during cycle T+65.
REQ-012 Divide by zero (conditioned b==0) SHALL skip BUSY, go directly to DONE (done in cycle T+1), and produce:
- quotient = all ones;
- remainder = conditioned dividend.
REQ-013 Signed sign fix-up SHALL be:
- quotient negated when sign(a) != sign(b);
- remainder negated when a is negative.
REQ-014 Signed overflow (-2^63 / -1, word=0) SHALL yield quotient 0x8000_0000_0000_0000 and remainder 0.
REQ-015 result SHALL be the quotient for DIV/DIVU and the remainder for REM/REMU.
REQ-016 When word=1, result SHALL be the sign-extension of bit 31 of the 64-bit outcome, including for DIVU/REMU.
REQ-017 result SHALL be registered and held stable from DONE until the next accept; done SHALL be 0 outside DONE.
REQ-018 stall SHALL equal (IDLE & valid & !flush) | BUSY; stall SHALL be 0 in DONE so the consumer advances.
REQ-019 valid asserted during BUSY or DONE SHALL be ignored; no queuing.
REQ-020 flush=1 in any state SHALL force IDLE on the next edge, with no done pulse; result is not updated.
REQ-021 flush and valid asserted in the same IDLE cycle SHALL result in no accept.
REQ-022 flush in DONE SHALL suppress nothing already emitted: done is still 1 that cycle, and the FSM goes to IDLE.

Reset
REQ-023 reset=1 SHALL force on the next edge:
- state=IDLE, counter=0, done=0, result=0, all internal operand/remainder registers=0.
REQ-024 reset SHALL take priority over flush and valid, and SHALL abort a BUSY operation with no done pulse.
REQ-025 After reset deasserts, ready=1 and stall=valid.

Verification
REQ-026 The bench SHALL cover DIVU, word=0: a=100, b=7 accepted at T -> stall high T..T+64, done=1 at T+65, result=14; repeat with REMU -> result=2.
REQ-027 The bench SHALL cover DIV, word=0: a=-7, b=2 -> result=0xFFFF_FFFF_FFFF_FFFD (-3); REM with the same operands -> result=0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-028 The bench SHALL cover divide by zero: DIVU, a=5, b=0 -> done at T+1, result=all ones; REM, a=-5, b=0 -> result=-5.
REQ-029 The bench SHALL cover word ops:
- DIVW: a=0x8000_0000, b=0xFFFF_FFFF -> result=0xFFFF_FFFF_8000_0000.
- DIVUW: a=0xFFFF_FFFF_FFFF_FFFE, b=1 -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-030 The bench SHALL cover signed overflow: DIV, word=0: a=0x8000_0000_0000_0000, b=-1 -> result=0x8000_0000_0000_0000; REM with the same operands -> result=0.
REQ-031 The bench SHALL cover abort: flush at T+20 of a BUSY op -> IDLE at T+21, no done pulse, then a new request is accepted normally; reset at T+30 of a BUSY op -> same outcome, with result=0.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 64-bit restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero bypasses the iteration loop.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  localparam int unsigned W  = 64;
  localparam int unsigned HW = 32;
  localparam int unsigned CW = 7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rem_sel_q;
  logic            word_q;
  logic            qneg_q;
  logic            rneg_q;
  logic [W-1:0]    dvsr_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    quo_q;

  logic            sgn;
  logic [W-1:0]    a_cond;
  logic [W-1:0]    b_cond;
  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W:0]      rem_sh;
  logic            ge;
  logic [W-1:0]    rem_nx;
  logic [W-1:0]    quo_nx;

  // Select quotient or remainder, then sign-extend bit 31 for W forms.
  function automatic logic [W-1:0] pick(input logic rsel, input logic wsel,
                                        input logic [W-1:0] q, input logic [W-1:0] r);
    logic [W-1:0] s;
    s = rsel ? r : q;
    return wsel ? {{HW{s[HW-1]}}, s[HW-1:0]} : s;
  endfunction

  // Operand conditioning and magnitudes for the unsigned datapath.
  always_comb begin
    sgn    = ~op[0];
    a_cond = a;
    b_cond = b;
    if (word) begin
      a_cond = sgn ? {{HW{a[HW-1]}}, a[HW-1:0]} : {{HW{1'b0}}, a[HW-1:0]};
      b_cond = sgn ? {{HW{b[HW-1]}}, b[HW-1:0]} : {{HW{1'b0}}, b[HW-1:0]};
    end
    a_neg = sgn & a_cond[W-1];
    b_neg = sgn & b_cond[W-1];
    a_mag = a_neg ? W'(-a_cond) : a_cond;
    b_mag = b_neg ? W'(-b_cond) : b_cond;
  end

  // One restoring step; the extra remainder bit covers divisors above 2^63.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    ge     = rem_sh >= {1'b0, dvsr_q};
    rem_nx = ge ? W'(rem_sh - {1'b0, dvsr_q}) : rem_sh[W-1:0];
    quo_nx = {quo_q[W-2:0], ge};
  end

  assign ready = (state == IDLE);
  assign stall = ((state == IDLE) & valid & ~flush) | (state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      result    <= '0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid) begin
            rem_sel_q <= op[1];
            word_q    <= word;
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            dvsr_q    <= b_mag;
            rem_q     <= '0;
            quo_q     <= a_mag;
            if (b_cond == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              cnt    <= '0;
              result <= pick(op[1], word, '1, a_cond);
            end else begin
              state <= BUSY;
              cnt   <= CW'(W);
            end
          end
        end
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - CW'(1);
          // Last step: fix signs on the freshly computed values.
          if (cnt == CW'(1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= pick(rem_sel_q, word_q,
                           qneg_q ? W'(-quo_nx) : quo_nx,
                           rneg_q ? W'(-rem_nx) : rem_nx);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall, results, divide-by-zero,
// overflow, W forms, and flush/reset abort of an in-flight operation.
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [1:0]  op;
  logic        word;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        ready;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int tests;
  int fails;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  div_seq dut (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .op     (op),
    .word   (word),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to its done pulse; valid is re-raised
  // mid-operation to confirm it is ignored while busy.
  task automatic do_op(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] exp, input int lat);
    int  n;
    int  stall_lo;
    bit  got;
    @(posedge clk); #1;
    valid = 1'b1; op = o; word = w; a = av; b = bv;
    @(negedge clk);
    check({tag, " stall_at_T"}, 64'(stall), 64'd1);
    check({tag, " ready_at_T"}, 64'(ready), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0; stall_lo = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (!stall) stall_lo++;
      if (n == 10) begin valid = 1'b1; a = 64'd9; b = 64'd3; end
      if (n == 13) valid = 1'b0;
    end
    valid = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy_stall_gaps"}, 64'(stall_lo), 64'd0);
    check({tag, " stall_in_done"}, 64'(stall), 64'd0);
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check({tag, " result_held"}, result, exp);
    check({tag, " ready_after"}, 64'(ready), 64'd1);
  endtask

  // Start DIVU 100/7, then flush or reset during cycle T+k.
  task automatic abort_op(input string tag, input bit use_reset, input int k,
                          input logic [63:0] exp_res);
    int dn;
    dn = 0;
    @(posedge clk); #1;
    valid = 1'b1; op = OP_DIVU; word = 1'b0; a = 64'd100; b = 64'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    @(negedge clk);
    if (done) dn++;
    check({tag, " busy_before_abort"}, 64'(ready), 64'd0);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;
    check({tag, " idle_next"}, 64'(ready), 64'd1);
    check({tag, " stall_idle"}, 64'(stall), 64'd0);
    check({tag, " result_kept"}, result, exp_res);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check({tag, " no_done_pulse"}, 64'(dn), 64'd0);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; valid = 1'b0; op = 2'd0; word = 1'b0;
    a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset ready", 64'(ready), 64'd1);
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);

    // flush alongside valid in IDLE must not accept
    valid = 1'b1; flush = 1'b1; op = OP_DIVU; a = 64'd5; b = 64'd0;
    #1 check("flush_valid stall", 64'(stall), 64'd0);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    check("flush_valid no_accept", 64'(ready), 64'd1);
    @(negedge clk);
    check("flush_valid no_done", 64'(done), 64'd0);

    do_op("divu",  OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    do_op("remu",  OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    do_op("div",   OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem",   OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("divu0", OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem0",  OP_REM,  1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
    do_op("divw",  OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 65);
    do_op("divuw", OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFE, 65);

    abort_op("flush_abort", 1'b0, 20, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("after_flush", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    abort_op("reset_abort", 1'b1, 30, 64'd0);
    do_op("after_reset", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);

    do_op("ovf_div", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 65);
    do_op("ovf_rem", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
